// File: rtl/prog_sequencer.sv
// Program sequencer for the butterfly processor: fetches from program memory,
// resolves control opcodes locally and forwards EXEC words to the datapath.
module prog_sequencer #(
    parameter int Psize  = 6,
    parameter int Isize  = 16,
    parameter int Sdepth = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             stall,
    input  logic             zflag,
    input  logic             evt,
    input  logic [Isize:0]   I,
    output logic [Psize-1:0] address,
    output logic [Isize:0]   instr,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int SP_W  = $clog2(Sdepth + 1);
    localparam int IDX_W = (Sdepth > 1) ? $clog2(Sdepth) : 1;

    localparam logic [2:0] OP_EXEC = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_WAIT = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAITEV
    } state_t;

    state_t            state_q, state_d;
    logic [Psize-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [Isize:0]    instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              push_en;

    logic [Psize-1:0]  stack_q [Sdepth];

    logic [2:0]        opcode;
    logic [Psize-1:0]  target;
    logic [Psize-1:0]  pc_inc;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign opcode = I[Isize:Isize-2];
    assign target = I[Psize-1:0];
    assign pc_inc = pc_q + Psize'(1);
    assign wr_idx = IDX_W'(sp_q);
    assign rd_idx = IDX_W'(sp_q - SP_W'(1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        error_d = error_q;
        push_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                // start wins over stall while idle
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    sp_d    = '0;
                    error_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    case (opcode)
                        OP_EXEC: begin
                            instr_d = I;
                            valid_d = 1'b1;
                            pc_d    = pc_inc;
                        end
                        OP_JMP:  pc_d = target;
                        OP_JZ:   pc_d = zflag ? target : pc_inc;
                        OP_CALL: begin
                            if (sp_q == SP_W'(Sdepth)) begin
                                error_d = 1'b1;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                pc_d    = target;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                error_d = 1'b1;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                pc_d = stack_q[rd_idx];
                                sp_d = sp_q - SP_W'(1);
                            end
                        end
                        OP_WAIT: begin
                            if (evt) pc_d = pc_inc;
                            else     state_d = S_WAITEV;
                        end
                        OP_HALT: begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        default: begin
                            error_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
            S_WAITEV: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (evt) begin
                        state_d = S_RUN;
                        pc_d    = pc_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Stack contents are plain storage; only the pointer needs a reset value.
    always_ff @(posedge Clock) begin
        if (push_en) stack_q[wr_idx] <= pc_inc;
    end

    assign address     = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;

endmodule
